// File: rtl/router_pkg.sv
// router_pkg: types and helpers shared by param_router and its FIFOs.
//   fifo_status_t : {full, empty} flags reported by each output FIFO
//   addr_width()  : width of a port index for a given port count
package router_pkg;

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_status_t;

  // Keeps the index at least one bit wide so a degenerate port count
  // still produces a legal vector.
  function automatic int addr_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// router_fifo: single-clock synchronous FIFO, one per router output.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   push, wdata  : write wdata at the tail (ignored while full)
//   pop          : remove the head word (ignored while empty)
//   rdata        : head word, forced to 0 while empty
//   full, empty  : decoded from the registered occupancy count
module router_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push_ok;
  logic                  pop_ok;

  // Flags come only from the registered count, so a pop in the same cycle
  // never makes a full FIFO accept input.
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; pointers and count alone define contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/param_router.sv
// param_router: 1-to-NUM_PORTS router with one FIFO per output channel.
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   din, addr, din_valid : input word and its destination port
//   din_ready            : addressed FIFO is not full
//   dout                 : port i at [i*DATA_WIDTH +: DATA_WIDTH], 0 when empty
//   dout_valid           : bit i set while FIFO i holds a word
//   dout_ready           : consumer i takes the head word
module param_router
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_WIDTH = addr_width(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic                             din_valid,
  output logic                             din_ready,
  input  logic [ADDR_WIDTH-1:0]            addr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  dout,
  output logic [NUM_PORTS-1:0]             dout_valid,
  input  logic [NUM_PORTS-1:0]             dout_ready
);

  typedef logic [DATA_WIDTH-1:0] word_t;

  fifo_status_t          status [NUM_PORTS];
  word_t                 rdata  [NUM_PORTS];
  logic [NUM_PORTS-1:0]  push;

  // Only the addressed FIFO's fullness gates the producer, so a stalled
  // output never holds up words bound elsewhere.
  assign din_ready = !status[addr].full;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign push[i] = din_valid && din_ready && (addr == ADDR_WIDTH'(i));

    router_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .pop   (dout_ready[i]),
      .wdata (din),
      .rdata (rdata[i]),
      .full  (status[i].full),
      .empty (status[i].empty)
    );

    assign dout_valid[i]                        = !status[i].empty;
    assign dout[i*DATA_WIDTH +: DATA_WIDTH]     = rdata[i];
  end

endmodule

// File: doc/param_router.md
# param_router

Parametrised 1-to-NUM_PORTS data router with a valid/ready handshake on every side and a FIFO per output channel. Each accepted input word is steered by `addr` into the FIFO of the addressed output, so a stalled output never blocks traffic to the other outputs. The block sits on the chip I/O path between a single producer and NUM_PORTS independent consumers, and is the buffered successor to the four-output combinational demux.

## Interface
- DATA_WIDTH, 32, width of one data word
- NUM_PORTS, 4, number of output channels; power of two, at least 2
- FIFO_DEPTH, 4, words per output FIFO; power of two, at least 2
- clk  input  1  sole clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- din  input  DATA_WIDTH  input word
- din_valid  input  1  din/addr hold a word to transfer
- din_ready  output  1  the addressed FIFO can accept a word this cycle
- addr  input  $clog2(NUM_PORTS)  destination output index
- dout  output  NUM_PORTS*DATA_WIDTH  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- dout_valid  output  NUM_PORTS  bit i set when FIFO i is non-empty
- dout_ready  input  NUM_PORTS  consumer i accepts the head word

## Operation
- Push: when `din_valid && din_ready`, `din` is written at the tail of FIFO[addr]. `din` and `addr` are sampled only in that cycle.
- `din_ready = !full[addr]`. This path is combinational from `addr`. There is no bypass: a full FIFO refuses input even when it is popped in the same cycle.
- Pop: when `dout_valid[i] && dout_ready[i]`, the head of FIFO i is removed.
- Each FIFO keeps read/write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, plus an occupancy count of $clog2(FIFO_DEPTH)+1 bits.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
- Simultaneous push and pop on the same non-full, non-empty FIFO: both take effect and the count is unchanged.
- Push into an empty FIFO while that FIFO's `dout_ready` is high: no pop occurs that cycle, because valid was low. The word appears next cycle.
- The `dout` slice of port i shows mem_i[rd_ptr_i] when non-empty and is forced to 0 when empty.
- `din_valid` low: no state changes in the input path, whatever the value of `addr`.
- Ordering: words to the same port leave in acceptance order. There is no ordering guarantee across ports.
- The pops of all ports proceed independently and concurrently in the same cycle.

## Timing
- Reset values: all pointers and counts 0, `dout_valid` all 0, `dout` all 0. `din_ready` = 1 while `reset` is high, since every FIFO is empty.
- A push while `reset` is high is ignored. Reset mid-operation discards all buffered words on the next edge.
- Latency: a word accepted at edge N is visible on `dout`/`dout_valid` after edge N, so it is poppable in cycle N+1. Minimum latency is 1 cycle.
- Throughput: one push per cycle total and one pop per cycle per port.
- Each `dout_valid` bit is a registered state decode with no combinational path from `din_valid`. The only combinational paths from `dout_ready` are to internal next-state logic, never to outputs.

## Structure
- Shared package `router_pkg`:
  - localparam helper function for ADDR_WIDTH = $clog2(NUM_PORTS)
  - a common `word_t` typedef parameterised through the module
  - a `fifo_status_t` struct {full, empty}
- Sub-module `router_fifo`: single-clock synchronous FIFO with parameters DATA_WIDTH and FIFO_DEPTH, ports push/pop/wdata/rdata/full/empty. Instantiated NUM_PORTS times in a generate loop.
- The top level holds only the addr decode, the `din_ready` mux and output flattening.

## Test plan
- Reset, then idle: `dout_valid`=0000, `dout`=0, `din_ready`=1; hold 5 cycles with no change.
- Push 0xA5A5_0001 to addr 2 with all `dout_ready`=0 → cycle later `dout_valid`=0100, slice 2 = 0xA5A5_0001; other slices 0.
- Fill port 1 with 4 words and `dout_ready[1]`=0 → `din_ready` is 0 for addr 1 but 1 for addr 0. Then a push to port 0 is accepted.
- Port 3 half full, push and pop in the same cycle for 8 cycles → count stays 2, words exit in order, pointer wrap exercised.
- Burst 16 pushes round-robin over ports 0-3 with all `dout_ready`=1 → every word appears on its port exactly 1 cycle after acceptance, with no loss.
- Assert `reset` with 3 words queued on port 0 plus a concurrent push → after the edge `dout_valid`=0000; the pushed word never appears.
